dab_pwm_modulator: RTL and testbench

- Downstream stage of the DAB controller: consumes the signed 9-bit tau1, tau2 and phi angle words and produces the eight gate signals for the primary and secondary full bridges.
- Triple-phase-shift modulation: a 9-bit phase counter spans one switching period; four leg waveforms are derived from it.
- Per-leg dead time, glitch-free double-buffered updates at period wrap, and a latched fault trip.

---
 rtl/dab_pwm_modulator.sv | 160 ++++++++++++++++
 tb/tb_dab_pwm_modulator.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dab_pwm_modulator.sv
// Triple-phase-shift gate generator for a dual active bridge: a prescaled 9-bit phase
// counter drives four leg targets, each leg with its own dead-time counter.
module dab_pwm_modulator #(
  parameter int DEADTIME = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fault,
  input  logic              load,
  input  logic signed [8:0] tau1,
  input  logic signed [8:0] tau2,
  input  logic signed [8:0] phi,
  input  logic [15:0]       div,
  output logic [7:0]        gate,
  output logic              upd,
  output logic              running,
  output logic              tripped
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_TRIP} state_t;

  state_t state, state_nx;

  logic [8:0]        ph;
  logic [15:0]       presc;
  logic signed [8:0] p_tau1, p_tau2, p_phi;
  logic [15:0]       p_div;
  logic              pv;
  logic [7:0]        a_tau1, a_tau2;
  logic [8:0]        a_phi;
  logic [15:0]       a_div;
  logic              run_d;

  logic signed [8:0] src_tau1, src_tau2, src_phi;
  logic [15:0]       src_div;
  logic              enter, run_go, adv, wrap, xfer;
  logic [8:0]        b_sum, q, s_sum;
  logic [3:0]        tgt, tgt_q;
  logic [7:0]        cnt [4];
  logic              first;

  function automatic logic [7:0] sat_tau(input logic signed [8:0] v);
    return v[8] ? 8'd0 : v[7:0];
  endfunction

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (enable && !fault) state_nx = S_RUN;
      S_RUN:   if (fault) state_nx = S_TRIP;
               else if (!enable) state_nx = S_IDLE;
      S_TRIP:  if (!enable) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // A load in the same cycle as a transfer wins over the older pending copy.
  assign src_tau1 = load ? tau1 : p_tau1;
  assign src_tau2 = load ? tau2 : p_tau2;
  assign src_phi  = load ? phi  : p_phi;
  assign src_div  = load ? div  : p_div;

  assign enter  = (state == S_IDLE) && (state_nx == S_RUN);
  assign run_go = (state == S_RUN) && (state_nx == S_RUN);
  assign adv    = run_go && (presc == a_div);
  assign wrap   = adv && (ph == 9'd511);
  assign xfer   = enter || (wrap && (pv || load));
  assign first  = !run_d;

  // Mod-512 targets: subtracting 256 is the same as adding 256.
  assign b_sum  = ph + 9'd256 + {1'b0, a_tau1};
  assign q      = ph - a_phi;
  assign s_sum  = q + 9'd256 + {1'b0, a_tau2};
  assign tgt[0] = ~ph[8];
  assign tgt[1] = ~b_sum[8];
  assign tgt[2] = ~q[8];
  assign tgt[3] = ~s_sum[8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      run_d   <= 1'b0;
      running <= 1'b0;
      tripped <= 1'b0;
      upd     <= 1'b0;
      ph      <= '0;
      presc   <= '0;
      p_tau1  <= '0;
      p_tau2  <= '0;
      p_phi   <= '0;
      p_div   <= '0;
      pv      <= 1'b0;
      a_tau1  <= '0;
      a_tau2  <= '0;
      a_phi   <= '0;
      a_div   <= '0;
    end else begin
      state   <= state_nx;
      run_d   <= (state == S_RUN);
      running <= (state_nx == S_RUN);
      tripped <= (state_nx == S_TRIP);
      upd     <= wrap && (pv || load);
      if (load) begin
        p_tau1 <= tau1;
        p_tau2 <= tau2;
        p_phi  <= phi;
        p_div  <= div;
      end
      if (xfer) pv <= 1'b0;
      else if (load) pv <= 1'b1;
      if (xfer) begin
        a_tau1 <= sat_tau(src_tau1);
        a_tau2 <= sat_tau(src_tau2);
        a_phi  <= src_phi;
        a_div  <= src_div;
      end
      if (run_go) begin
        if (adv) begin
          presc <= '0;
          ph    <= ph + 9'd1;
        end else begin
          presc <= presc + 16'd1;
        end
      end else begin
        presc <= '0;
        ph    <= '0;
      end
    end
  end

  // Per leg: a target change (or the first RUN cycle) drops both gates and restarts
  // the dead-time count; the new gate asserts once the count has drained to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate  <= '0;
      tgt_q <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (!run_go) begin
          gate[2*i]   <= 1'b0;
          gate[2*i+1] <= 1'b0;
          cnt[i]      <= 8'(DEADTIME);
        end else if (first || (tgt[i] != tgt_q[i])) begin
          gate[2*i]   <= 1'b0;
          gate[2*i+1] <= 1'b0;
          cnt[i]      <= 8'(DEADTIME);
          tgt_q[i]    <= tgt[i];
        end else if (cnt[i] != 8'd0) begin
          cnt[i] <= cnt[i] - 8'd1;
        end else begin
          gate[2*i]   <= tgt_q[i];
          gate[2*i+1] <= ~tgt_q[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_dab_pwm_modulator.sv
// Bench for dab_pwm_modulator: expected gate/upd events (cycle since enable, value) are
// queued by the stimulus and consumed by a monitor whenever the outputs change.
module tb_dab_pwm_modulator;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              enable = 1'b0;
  logic              fault = 1'b0;
  logic              load = 1'b0;
  logic signed [8:0] tau1 = '0;
  logic signed [8:0] tau2 = '0;
  logic signed [8:0] phi = '0;
  logic [15:0]       div = '0;
  logic [7:0]        gate;
  logic              upd;
  logic              running;
  logic              tripped;

  dab_pwm_modulator #(.DEADTIME(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fault(fault), .load(load),
    .tau1(tau1), .tau2(tau2), .phi(phi), .div(div),
    .gate(gate), .upd(upd), .running(running), .tripped(tripped)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int base = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  // Entry: {kind (0 gate change, 1 upd pulse), cycle since enable, value}
  logic [23:0] exp_q[$];
  bit          mon_on = 1'b0;
  logic [7:0]  prev_gate = '0;
  int          overlap = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic mon_evt(input logic kind, input logic [7:0] val);
    logic [23:0] obs;
    logic [23:0] e;
    obs = {kind, 15'(cyc - base), val};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_evt: kind=%0d cycle=%0d val=%02h, nothing expected",
               kind, cyc - base, val);
    end else begin
      e = exp_q.pop_front();
      if (e !== obs) begin
        errors++;
        $display("FAIL evt: got kind=%0d cycle=%0d val=%02h expected kind=%0d cycle=%0d val=%02h",
                 obs[23], obs[22:8], obs[7:0], e[23], e[22:8], e[7:0]);
      end
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (upd === 1'b1) mon_evt(1'b1, 8'h01);
      if (gate !== prev_gate) mon_evt(1'b0, gate);
    end
    prev_gate = gate;
    for (int i = 0; i < 4; i++)
      if (gate[2*i] && gate[2*i+1]) overlap++;
  end

  task automatic eg(input int c, input logic [7:0] g);
    exp_q.push_back({1'b0, 15'(c), g});
  endtask

  task automatic eu(input int c);
    exp_q.push_back({1'b1, 15'(c), 8'h01});
  endtask

  task automatic wait_until(input int c);
    while (cyc - base < c) @(negedge clk);
  endtask

  task automatic do_load(input int t1, input int t2, input int p, input int d);
    tau1 = 9'(t1);
    tau2 = 9'(t2);
    phi  = 9'(p);
    div  = 16'(d);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic start_run();
    enable = 1'b1;
    base   = cyc + 1;
  endtask

  task automatic drain(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // tau1=tau2=255, phi=64, div=0 waveform, first period and the next wrap
  task automatic push_sq_start();
    eg(10, 8'hA1);  eg(11, 8'hA5);  eg(65, 8'h85);  eg(66, 8'h05);
    eg(74, 8'h15);  eg(75, 8'h55);  eg(257, 8'h54); eg(258, 8'h50);
    eg(266, 8'h52); eg(267, 8'h5A); eg(321, 8'h4A); eg(322, 8'h0A);
    eg(330, 8'h2A); eg(331, 8'hAA);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_gate", gate, 0);
    chk("reset_upd", upd, 0);
    chk("reset_running", running, 0);
    chk("reset_tripped", tripped, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_running", running, 0);

    // Run 1: near-square waves, s1 lags p1 by 64, then a one-clock fault.
    do_load(255, 255, 64, 0);
    mon_on = 1'b1;
    push_sq_start();
    eg(513, 8'hA8); eg(514, 8'hA0); eg(522, 8'hA1); eg(523, 8'hA5);
    eg(540, 8'h00);
    start_run();
    @(negedge clk);
    chk("run1_running", running, 1);
    wait_until(539);
    fault = 1'b1;
    @(negedge clk);
    fault = 1'b0;
    @(negedge clk);
    chk("trip_tripped", tripped, 1);
    chk("trip_running", running, 0);
    repeat (5) @(negedge clk);
    chk("trip_latched", tripped, 1);
    drain("run1_events");
    enable = 1'b0;
    @(negedge clk);
    chk("trip_clear", tripped, 0);
    chk("idle_after_trip", running, 0);

    // Run 2: restart from ph=0, two loads before the wrap; the later one
    // (tau1=-20 -> 0, phi=-128) takes effect at the wrap only.
    push_sq_start();
    eu(512);
    eg(513, 8'h08); eg(522, 8'h59); eg(641, 8'h49); eg(642, 8'h09);
    eg(650, 8'h29); eg(651, 8'hA9); eg(769, 8'hA0); eg(778, 8'hA6);
    eg(897, 8'h86); eg(898, 8'h06); eg(906, 8'h16); eg(907, 8'h56);
    eg(1025, 8'h50); eg(1034, 8'h59);
    start_run();
    wait_until(200);
    do_load(100, 50, 0, 5);
    wait_until(300);
    do_load(-20, 255, -128, 0);
    wait_until(1040);
    drain("run2_events");

    // Asynchronous reset with gates active.
    mon_on = 1'b0;
    #2;
    rst_n  = 1'b0;
    enable = 1'b0;
    #1;
    chk("async_rst_gate", gate, 0);
    chk("async_rst_running", running, 0);
    chk("async_rst_upd", upd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_running", running, 0);
    chk("post_rst_gate", gate, 0);

    // Run 3: div=3, tau1=128 -> p2 lags p1 by 512 clocks.
    do_load(128, 0, 0, 3);
    mon_on = 1'b1;
    eg(10, 8'h99);   eg(513, 8'h91);  eg(522, 8'h95);  eg(1025, 8'h04);
    eg(1034, 8'h66); eg(1537, 8'h62); eg(1546, 8'h6A); eg(2049, 8'h08);
    eg(2058, 8'h99);
    start_run();
    wait_until(2065);
    drain("run3_events");
    chk("no_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
